// File: rtl/utils_pkg.sv
// utils_pkg: packet and state types shared by the packet buffer stages.
package utils_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0]  header;
        logic [3:0]  opcode;
        logic [63:0] data;
        logic [3:0]  error;
        state_t      m_state;
    } packet_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping slot index 0..DEPTH-1 that steps on adv.
module fifo_ptr #(
    parameter int DEPTH      = 16,
    parameter int COUNT_SIZE = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  adv,
    output logic [COUNT_SIZE-1:0] ptr
);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn)
            ptr <= '0;
        else if (adv)
            ptr <= (ptr == COUNT_SIZE'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/generic_fifo.sv
// generic_fifo: single-clock show-ahead FIFO of packet_t entries.
// Define GENERIC_FIFO_ASSERT_EN to compile in overflow/underflow/flag checks.
module generic_fifo
    import utils_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int COUNT_SIZE = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic                  pop,
    output logic [COUNT_SIZE-1:0] wr_ptr,
    output logic [COUNT_SIZE-1:0] rd_ptr,
    output logic                  full,
    output logic                  empty,
    input  packet_t               data_in,
    output packet_t               data_out
);

    packet_t               mem [DEPTH];
    logic [COUNT_SIZE:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (COUNT_SIZE + 1)'(DEPTH));
    // a pop on the same edge frees the head slot, so a full FIFO may still accept
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    fifo_ptr #(.DEPTH(DEPTH), .COUNT_SIZE(COUNT_SIZE)) u_wr_ptr (
        .aclk   (aclk),
        .resetn (resetn),
        .adv    (do_push),
        .ptr    (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH), .COUNT_SIZE(COUNT_SIZE)) u_rd_ptr (
        .aclk   (aclk),
        .resetn (resetn),
        .adv    (do_pop),
        .ptr    (rd_ptr)
    );

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn)
            count <= '0;
        else if (do_push != do_pop)
            count <= do_push ? count + 1'b1 : count - 1'b1;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef GENERIC_FIFO_ASSERT_EN
    a_overflow: assert property (@(posedge aclk) disable iff (!resetn) !(push && full && !pop))
        else $error("generic_fifo overflow");
    a_underflow: assert property (@(posedge aclk) disable iff (!resetn) !(pop && empty))
        else $error("generic_fifo underflow");
    a_flags: assert property (@(posedge aclk) disable iff (!resetn) !(full && empty))
        else $error("generic_fifo full and empty together");
    a_count: assert property (@(posedge aclk) disable iff (!resetn) count <= (COUNT_SIZE + 1)'(DEPTH))
        else $error("generic_fifo count out of range");
`else
`endif

endmodule

// File: tb/tb_generic_fifo.sv
// tb_generic_fifo: directed plus random checks of generic_fifo against a queue model.
module tb_generic_fifo;
    import utils_pkg::*;

    localparam int DEPTH = 16;
    localparam int CS    = $clog2(DEPTH);

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    packet_t       data_in = '0;
    packet_t       data_out;
    logic [CS-1:0] wr_ptr;
    logic [CS-1:0] rd_ptr;
    logic          full;
    logic          empty;

    int      checks = 0;
    int      errors = 0;
    packet_t q[$];
    int      np = 0;
    int      nr = 0;

    always #5 aclk = ~aclk;

    generic_fifo #(.DEPTH(DEPTH)) dut (
        .aclk     (aclk),
        .resetn   (resetn),
        .push     (push),
        .pop      (pop),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .full     (full),
        .empty    (empty),
        .data_in  (data_in),
        .data_out (data_out)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic packet_t mk(input logic [7:0] h, input logic [3:0] o, input logic [63:0] d,
                                   input logic [3:0] e, input state_t m);
        mk = '{header: h, opcode: o, data: d, error: e, m_state: m};
    endfunction

    function automatic packet_t rnd();
        rnd = mk(8'($urandom), 4'($urandom), {$urandom, $urandom}, 4'($urandom),
                 state_t'($urandom_range(0, 4)));
    endfunction

    // pointers are just the accepted-operation totals modulo DEPTH
    task automatic check_model();
        chk("wr_ptr", 128'(wr_ptr), 128'(np % DEPTH));
        chk("rd_ptr", 128'(rd_ptr), 128'(nr % DEPTH));
        chk("full", 128'(full), 128'(q.size() == DEPTH));
        chk("empty", 128'(empty), 128'(q.size() == 0));
        if (q.size() > 0)
            chk("data_out", 128'(data_out), 128'(q[0]));
    endtask

    task automatic cycle(input logic p, input logic r, input packet_t d, output packet_t s);
        bit ap;
        bit ar;
        push = p;
        pop = r;
        data_in = d;
        ap = p && (q.size() < DEPTH || r);
        ar = r && (q.size() > 0);
        s = data_out;
        if (ar)
            chk("pop_head", 128'(s), 128'(q[0]));
        @(posedge aclk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        if (ar) begin
            void'(q.pop_front());
            nr++;
        end
        if (ap) begin
            q.push_back(d);
            np++;
        end
        check_model();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wr"}, 128'(wr_ptr), 128'(0));
        chk({tag, "_rd"}, 128'(rd_ptr), 128'(0));
        chk({tag, "_empty"}, 128'(empty), 128'(1));
        chk({tag, "_full"}, 128'(full), 128'(0));
        chk({tag, "_dout"}, 128'(data_out), 128'(0));
    endtask

    initial begin
        packet_t  s;
        packet_t  ff_p;
        packet_t  p;
        logic [CS-1:0] r0;
        ff_p = mk(8'hFF, 4'hA, 64'hDEAF_DEAD_DEAF_DEAD, 4'hE, ST_IDLE);

        #100;
        check_reset("reset");
        @(posedge aclk);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, ff_p, s);
            cycle(1'b0, 1'b0, '0, s);
        end
        chk("wr_ptr_12", 128'(wr_ptr), 128'(12));
        chk("empty_12", 128'(empty), 128'(0));
        chk("full_12", 128'(full), 128'(0));

        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, '0, s);
            chk("hdr_ff_a", 128'(s.header), 128'(8'hFF));
        end
        chk("rd_ptr_5", 128'(rd_ptr), 128'(5));

        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, mk(8'hAA, 4'hB, 64'h0000_DEAD_DEAF_0000, 4'hC,
                                 (i % 2 == 0) ? ST_HDR : ST_DATA), s);
            if (i == 8) begin
                chk("full_after_9", 128'(full), 128'(1));
                chk("wr_after_9", 128'(wr_ptr), 128'(5));
            end
        end
        chk("wr_after_drop", 128'(wr_ptr), 128'(5));
        chk("full_after_drop", 128'(full), 128'(1));

        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, '0, s);
            chk("hdr_ff_b", 128'(s.header), 128'(8'hFF));
        end
        chk("rd_ptr_10", 128'(rd_ptr), 128'(10));
        chk("full_after_pops", 128'(full), 128'(0));

        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, rnd(), s);
        chk("refull", 128'(full), 128'(1));
        cycle(1'b1, 1'b1, rnd(), s);
        chk("full_pushpop", 128'(full), 128'(1));

        for (int k = 0; k < DEPTH + 2 && !empty; k++)
            cycle(1'b0, 1'b1, '0, s);
        chk("drained", 128'(empty), 128'(1));

        r0 = rd_ptr;
        p = rnd();
        cycle(1'b1, 1'b1, p, s);
        chk("empty_pushpop_empty", 128'(empty), 128'(0));
        chk("empty_pushpop_rd", 128'(rd_ptr), 128'(r0));
        chk("empty_pushpop_head", 128'(data_out), 128'(p));
        cycle(1'b1, 1'b1, rnd(), s);
        chk("one_entry_pushpop", 128'(q.size()), 128'(1));

        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 50) % 2 == 0 ? 70 : 30;
            cycle(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) >= bias), rnd(), s);
        end

        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, rnd(), s);
        #2;
        resetn = 1'b0;
        #1;
        q.delete();
        np = 0;
        nr = 0;
        check_reset("midreset");
        @(posedge aclk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, rnd(), s);
        cycle(1'b0, 1'b1, '0, s);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
